apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB3 initiator: converts single-beat commands from a valid/ready request port into APB3 transfers.
- Drives on-fabric APB responders such as the timer and GPIO cores, which are APB3 slaves with 3-bit word address.
- Supports PREADY wait states, PSLVERR reporting and a wait-state timeout, and returns read data on a valid/ready response port.
- One transfer outstanding at a time.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/PADDR (byte address, passed through unmodified)
DATA_WIDTH, 32, width of write/read data
TIMEOUT_CYCLES, 255, consecutive ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
PCLK  in  1  clock; all logic rising-edge
PRESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  out  1  PSLVERR was sampled high at completion
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (async assert, sync release by system):
  - state IDLE.
  - All outputs 0, including PSEL, PENABLE, rsp_valid, PADDR, PWDATA, PWRITE and rsp_*.
  - Timeout counter 0.
- FSM states IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state == IDLE), decoded from registered state only; no combinational path from cmd_valid.
- IDLE:
  - On cmd_valid & cmd_ready, register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA.
  - Next state SETUP.
- SETUP: PSEL=1, PENABLE=0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - If PREADY=1: rsp_rdata=PRDATA for reads (0 for writes), rsp_err=PSLVERR, rsp_timeout=0; next state RESP.
  - If PREADY=0: counter increments.
  - If TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES with PREADY still 0: abort with rsp_timeout=1, rsp_err=0, rsp_rdata=0; next state RESP.
  - PREADY=1 on the limit cycle takes precedence (normal completion).
  - Counter clears on entry to SETUP.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1.
  - rsp_* held stable until rsp_ready, then IDLE.
  - rsp_ready low stalls indefinitely; no new command is accepted meanwhile.
- PADDR/PWRITE/PWDATA:
  - Stable from SETUP through the final ACCESS cycle.
  - Hold their last value in RESP/IDLE; no toggling when idle.
- Latency:
  - Command accepted at edge N: PSEL high after N, PENABLE high after N+1.
  - With zero wait states, rsp_valid high after N+2.
  - Minimum command-to-command interval is 4 cycles with rsp_ready held high.
- PSLVERR is sampled only in the ACCESS cycle with PREADY=1 and ignored otherwise. PRDATA is ignored for writes.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, the pending response is discarded, and the FSM returns to IDLE.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1. No overflow is possible because the abort occurs at the limit.

Decomposition:
- Package apb_master_pkg:
  - FSM state enum (IDLE/SETUP/ACCESS/RESP).
  - Response-code localparams (OKAY, SLVERR, TIMEOUT).
  - Helper for counter width.
- One sub-module, apb_wait_timer:
  - Clearable up-counter with limit compare and disable when the limit is 0.
  - Outputs an expired pulse.
- The FSM and datapath registers stay in apb_cmd_master.

Test Plan:
- Write 0x1234_5678 to 0x0000_0008, PREADY tied 1:
  - Exactly one SETUP and one ACCESS cycle, with PWRITE=1 and PADDR/PWDATA stable.
  - rsp_valid 3 cycles after accept, with rsp_err=0, rsp_timeout=0, rsp_rdata=0.
- Read 0x0000_0004 with PREADY low for 3 ACCESS cycles, then high with PRDATA=0xDEAD_BEEF:
  - PENABLE high for 4 cycles.
  - rsp_rdata=0xDEAD_BEEF; cmd_ready low throughout.
- Write with PSLVERR=1 on the completing cycle:
  - rsp_err=1.
  - PSLVERR=1 during earlier wait cycles has no effect.
- TIMEOUT_CYCLES=8 with PREADY never asserted:
  - Abort after 8 ACCESS cycles; PSEL/PENABLE drop.
  - rsp_timeout=1, rsp_rdata=0.
  - Second variant: PREADY=1 exactly on the 8th cycle → normal completion.
- Two back-to-back commands, rsp_ready held low 5 cycles after the first response:
  - rsp_* stable during the stall.
  - Second command not accepted until the handshake; second SETUP 1 cycle after return to IDLE.
- Assert PRESET during ACCESS of a read:
  - PSEL/PENABLE/rsp_valid are 0 in the same cycle.
  - After release, the next command completes normally with no stale response.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the APB command master.
package apb_master_pkg;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Completion codes held alongside the response
  localparam logic [1:0] RSP_OKAY    = 2'd0;
  localparam logic [1:0] RSP_SLVERR  = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT = 2'd2;

  // Wait counter width: enough to hold the limit, never narrower than 1 bit
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent with PREADY low and flags the cycle that
// reaches the limit. LIMIT of 0 turns the timer off entirely.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int LIMIT = 255,
  localparam int CW   = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam bit ENABLED = (LIMIT != 0);

  logic [CW-1:0] cnt;

  // Wait-cycle counter; the abort fires on the increment that reaches LIMIT,
  // so the count never needs to go past it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && ENABLED)  cnt <= cnt + 1'b1;
  end

  // Combinational: this low-PREADY cycle is the LIMIT-th one
  assign expired = ENABLED && inc && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command in, one APB transfer out,
// one valid/ready response back. Single transfer outstanding.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB3
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e state, state_nxt;

  logic       accept;
  logic       acc_done;
  logic       acc_abort;
  logic       tmr_inc;
  logic [1:0] rsp_code;

  // Everything handshake- and bus-facing decodes straight off the state
  // register, so reset pulls PSEL/PENABLE/rsp_valid down immediately.
  assign cmd_ready = (state == ST_IDLE);
  assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign PENABLE   = (state == ST_ACCESS);
  assign rsp_valid = (state == ST_RESP);

  assign accept    = cmd_valid && cmd_ready;
  assign acc_done  = (state == ST_ACCESS) && PREADY;
  assign tmr_inc   = (state == ST_ACCESS) && !PREADY;

  apb_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clr     (state == ST_SETUP),
    .inc     (tmr_inc),
    .expired (acc_abort)
  );

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: PREADY on the limit cycle wins because acc_abort needs PREADY low
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (acc_done || acc_abort) state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bus request fields: loaded on accept, otherwise held so the bus stays quiet
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else if (accept) begin
      PADDR  <= cmd_addr;
      PWRITE <= cmd_write;
      PWDATA <= cmd_wdata;
    end
  end

  // Response capture at the end of ACCESS; held through RESP until the next one
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_rdata <= '0;
      rsp_code  <= RSP_OKAY;
    end else if (acc_done) begin
      rsp_rdata <= PWRITE ? '0 : PRDATA;
      rsp_code  <= PSLVERR ? RSP_SLVERR : RSP_OKAY;
    end else if (acc_abort) begin
      rsp_rdata <= '0;
      rsp_code  <= RSP_TIMEOUT;
    end
  end

  assign rsp_err     = (rsp_code == RSP_SLVERR);
  assign rsp_timeout = (rsp_code == RSP_TIMEOUT);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed + randomized bench for apb_cmd_master with an inline APB responder.
module tb_apb_cmd_master;

  localparam int TO = 8;

  logic        PCLK, PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int tests = 0;
  int fails = 0;

  apb_cmd_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transaction. The responder holds PREADY low for `waits`
  // ACCESS cycles and then raises it. Expectations come from the protocol
  // rules: ready on cycle waits+1 completes normally if that is within TO
  // cycles, otherwise the master gives up after TO cycles.
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] rd,
                        input logic err_end, input logic err_early, input int stall);
    logic        exp_to, exp_err;
    logic [31:0] exp_rd;
    int          exp_acc, acc;
    exp_to  = (waits >= TO);
    exp_acc = exp_to ? TO : waits + 1;
    exp_rd  = (exp_to || wr) ? 32'h0 : rd;
    exp_err = !exp_to && err_end;

    chk1("idle_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    // scramble the command bus: the latched request must not follow it
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    chk1("setup_psel", PSEL, 1'b1);
    chk1("setup_penable", PENABLE, 1'b0);
    chk1("setup_ready", cmd_ready, 1'b0);
    chk("setup_paddr", PADDR, a);
    chk1("setup_pwrite", PWRITE, wr);
    chk("setup_pwdata", PWDATA, d);
    PREADY = 1'($urandom); PSLVERR = 1'($urandom);  // don't-care during SETUP
    tick();

    acc = 0;
    while (PENABLE === 1'b1 && acc < 64) begin
      chk1("acc_psel", PSEL, 1'b1);
      chk("acc_paddr", PADDR, a);
      chk("acc_pwdata", PWDATA, d);
      chk1("acc_pwrite", PWRITE, wr);
      chk1("acc_ready", cmd_ready, 1'b0);
      PREADY  = (acc == waits);
      PSLVERR = PREADY ? err_end : err_early;
      PRDATA  = PREADY ? rd : $urandom;
      acc++;
      tick();
    end
    PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;

    chk("access_cycles", acc, exp_acc);
    chk1("resp_psel", PSEL, 1'b0);
    chk1("resp_penable", PENABLE, 1'b0);
    chk1("resp_valid", rsp_valid, 1'b1);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk1("resp_err", rsp_err, exp_err);
    chk1("resp_timeout", rsp_timeout, exp_to);

    // stall: offer a new command that must not be taken, response must hold
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = $urandom;
      tick();
      chk1("stall_valid", rsp_valid, 1'b1);
      chk("stall_rdata", rsp_rdata, exp_rd);
      chk1("stall_err", rsp_err, exp_err);
      chk1("stall_timeout", rsp_timeout, exp_to);
      chk1("stall_ready", cmd_ready, 1'b0);
      chk1("stall_psel", PSEL, 1'b0);
      chk("stall_paddr", PADDR, a);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk1("done_valid", rsp_valid, 1'b0);
    chk1("done_ready", cmd_ready, 1'b1);
    chk1("done_psel", PSEL, 1'b0);
    chk("done_paddr_hold", PADDR, a);
  endtask

  initial begin
    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();

    // reset state
    chk1("rst_psel", PSEL, 1'b0);
    chk1("rst_penable", PENABLE, 1'b0);
    chk1("rst_valid", rsp_valid, 1'b0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk1("rst_pwrite", PWRITE, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk1("rst_err", rsp_err, 1'b0);
    chk1("rst_timeout", rsp_timeout, 1'b0);
    PRESET = 1'b0;
    tick();

    // zero-wait write
    do_txn(1'b1, 32'h0000_0008, 32'h1234_5678, 0, 32'h0, 1'b0, 1'b0, 0);
    // read with 3 wait states
    do_txn(1'b0, 32'h0000_0004, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    // write with PSLVERR on completion, and noise on earlier wait cycles
    do_txn(1'b1, 32'h0000_000C, 32'hA5A5_5A5A, 2, 32'h0, 1'b1, 1'b1, 0);
    // PSLVERR only during waits: must not be reported
    do_txn(1'b0, 32'h0000_0010, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b1, 0);
    // timeout: PREADY never comes
    do_txn(1'b0, 32'h0000_0014, 32'h0, 100, 32'h1111_2222, 1'b1, 1'b0, 0);
    // PREADY exactly on the limit cycle completes normally
    do_txn(1'b0, 32'h0000_0018, 32'h0, TO - 1, 32'h3333_4444, 1'b0, 1'b0, 0);
    // back-to-back with a 5-cycle response stall on the first
    do_txn(1'b1, 32'h0000_001C, 32'hCAFE_0001, 0, 32'h0, 1'b0, 1'b0, 5);
    do_txn(1'b0, 32'h0000_0000, 32'h0, 0, 32'hCAFE_0002, 1'b0, 1'b0, 0);

    // reset during ACCESS of a read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0004;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk1("mid_penable", PENABLE, 1'b1);
    PREADY = 1'b0;
    #2 PRESET = 1'b1;
    #1;
    chk1("mid_rst_psel", PSEL, 1'b0);
    chk1("mid_rst_penable", PENABLE, 1'b0);
    chk1("mid_rst_valid", rsp_valid, 1'b0);
    tick(); tick();
    PRESET = 1'b0;
    tick();
    chk1("post_rst_valid", rsp_valid, 1'b0);
    chk1("post_rst_ready", cmd_ready, 1'b1);
    do_txn(1'b0, 32'h0000_0008, 32'h0, 1, 32'h5555_AAAA, 1'b0, 1'b0, 0);

    // randomized transactions against the same protocol model
    for (int n = 0; n < 30; n++) begin
      do_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 10)), $urandom,
             1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
